// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the integer register file: default sizes,
// the clear-engine state encoding and the hard-wired zero register index.
package rv_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int REG_ZERO      = 0;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bundle of the register file. The core drives the
// master side; the register file is the slave.
interface regfile_mp_if
    import rv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NREAD = 2
) ();
    localparam int AW = $clog2(NREGS);

    // No request/acknowledge pairs: reads are combinational, RREADY[i] says
    // whether RDATA[i] is a committed operand this cycle, and BUSY=1 means
    // every write, reserve and read is refused until the clear engine ends.
    logic                  REG_WRITE;
    logic [AW-1:0]         ADDRESS3;
    logic [XLEN-1:0]       WRITE_DATA3;
    logic [NREAD*AW-1:0]   RADDR;
    logic [NREAD*XLEN-1:0] RDATA;
    logic [NREAD-1:0]      RREADY;
    logic                  RESERVE;
    logic [AW-1:0]         RESERVE_ADDR;
    logic                  BUSY;
    rf_state_t             dbg_state;

    modport master (
        output REG_WRITE, ADDRESS3, WRITE_DATA3, RADDR, RESERVE, RESERVE_ADDR,
        input  RDATA, RREADY, BUSY, dbg_state
    );

    modport slave (
        input  REG_WRITE, ADDRESS3, WRITE_DATA3, RADDR, RESERVE, RESERVE_ADDR,
        output RDATA, RREADY, BUSY, dbg_state
    );

endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Per-register pending-write bits and the per-port operand-ready logic.
module regfile_scoreboard #(
    parameter int NREGS = 32,
    parameter int NREAD = 2,
    parameter int AW    = 5
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_busy,
    input  logic                i_reg_write,
    input  logic [AW-1:0]       i_waddr,
    input  logic                i_reserve,
    input  logic [AW-1:0]       i_reserve_addr,
    input  logic [NREAD*AW-1:0] i_raddr,
    output logic [NREAD-1:0]    o_rready
);

    logic [NREGS-1:0] r_pending;

    // Reserve is applied after the write clear so a same-cycle pair leaves
    // the bit set for the new producer. Bit 0 is only ever reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending <= '0;
        end else if (!i_busy) begin
            for (int j = 1; j < NREGS; j++) begin
                if (i_reg_write && i_waddr == AW'(j)) r_pending[j] <= 1'b0;
                if (i_reserve && i_reserve_addr == AW'(j)) r_pending[j] <= 1'b1;
            end
        end
    end

    always_comb begin
        o_rready = '0;
        for (int i = 0; i < NREAD; i++) begin
            o_rready[i] = !i_busy &&
                          (!r_pending[i_raddr[i*AW +: AW]] ||
                           (i_reg_write && i_waddr == i_raddr[i*AW +: AW]));
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with hard-wired x0, write-to-read bypass,
// pending-write scoreboard and a post-reset sequential clear engine.
module regfile_mp
    import rv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NREAD = 2
) (
    input  logic         CLK,
    input  logic         RST,
    regfile_mp_if.slave  bus
);

    localparam int AW = $clog2(NREGS);

    rf_state_t       r_state;
    rf_state_t       w_state_nxt;
    logic [AW-1:0]   r_idx;
    logic            w_busy;
    logic            w_user_wr;
    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] r_ram [NREGS];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= RF_CLEAR;
            r_idx   <= AW'(1);
        end else begin
            r_state <= w_state_nxt;
            if (r_state == RF_CLEAR) r_idx <= r_idx + AW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == RF_CLEAR && r_idx == AW'(NREGS - 1)) w_state_nxt = RF_IDLE;
    end

    always_comb begin
        w_busy = (r_state == RF_CLEAR);
    end

    assign w_user_wr = bus.REG_WRITE && (bus.ADDRESS3 != AW'(REG_ZERO)) && !w_busy;

    // Single write port shared by the clear engine and writeback; entry 0 is
    // never written because the clear index starts at 1.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = bus.ADDRESS3;
        w_wdata = bus.WRITE_DATA3;
        if (!RST) begin
            if (w_busy) begin
                w_we    = 1'b1;
                w_waddr = r_idx;
                w_wdata = '0;
            end else begin
                w_we = w_user_wr;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_we) r_ram[w_waddr] <= w_wdata;
    end

    always_comb begin
        logic [AW-1:0] v_addr;
        bus.RDATA = '0;
        for (int i = 0; i < NREAD; i++) begin
            v_addr = bus.RADDR[i*AW +: AW];
            if (w_busy || v_addr == AW'(REG_ZERO)) begin
                bus.RDATA[i*XLEN +: XLEN] = '0;
            end else if (w_user_wr && bus.ADDRESS3 == v_addr) begin
                bus.RDATA[i*XLEN +: XLEN] = bus.WRITE_DATA3;
            end else begin
                bus.RDATA[i*XLEN +: XLEN] = r_ram[v_addr];
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NREAD (NREAD),
        .AW    (AW)
    ) u_scoreboard (
        .i_clk          (CLK),
        .i_rst          (RST),
        .i_busy         (w_busy),
        .i_reg_write    (bus.REG_WRITE),
        .i_waddr        (bus.ADDRESS3),
        .i_reserve      (bus.RESERVE),
        .i_reserve_addr (bus.RESERVE_ADDR),
        .i_raddr        (bus.RADDR),
        .o_rready       (bus.RREADY)
    );

    assign bus.BUSY      = w_busy;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default 32x32/2-port build plus a
// 64-bit, 16-register, 3-port build sharing the same clock.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(32), .NREGS(32), .NREAD(2)) bus1 ();
    regfile_mp_if #(.XLEN(64), .NREGS(16), .NREAD(3)) bus2 ();

    regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2)) dut1 (
        .CLK (clk),
        .RST (rst),
        .bus (bus1)
    );

    regfile_mp #(.XLEN(64), .NREGS(16), .NREAD(3)) dut2 (
        .CLK (clk),
        .RST (rst2),
        .bus (bus2)
    );

    task automatic idle1();
        bus1.REG_WRITE = 1'b0; bus1.ADDRESS3 = '0; bus1.WRITE_DATA3 = '0;
        bus1.RESERVE = 1'b0; bus1.RESERVE_ADDR = '0;
    endtask

    // Counts cycles with BUSY=1 starting from the current cycle (bounded).
    task automatic count_busy(input int which, output int n);
        n = 0;
        #1;
        while (((which == 1) ? bus1.BUSY : bus2.BUSY) === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_total++;
        if (bus1.BUSY !== 1'b1) $display("FAIL reset_busy: got %b want 1", bus1.BUSY);
        else n_pass++;
        n_total++;
        if (bus1.RDATA !== 64'd0) $display("FAIL reset_rdata: got %h want 0", bus1.RDATA);
        else n_pass++;
        n_total++;
        if (bus1.RREADY !== 2'b00) $display("FAIL reset_rready: got %b want 00", bus1.RREADY);
        else n_pass++;
        n_total++;
        if (bus2.BUSY !== 1'b1) $display("FAIL reset_busy2: got %b want 1", bus2.BUSY);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        count_busy(1, n);
        n_total++;
        if (n !== 31) $display("FAIL clear_cycles: got %0d want 31", n);
        else n_pass++;
        bus1.RADDR = {5'd9, 5'd5};
        #1;
        n_total++;
        if (bus1.RDATA !== 64'd0) $display("FAIL clear_rdata: got %h want 0", bus1.RDATA);
        else n_pass++;
        n_total++;
        if (bus1.RREADY !== 2'b11) $display("FAIL clear_rready: got %b want 11", bus1.RREADY);
        else n_pass++;
    endtask

    task automatic test_write_read();
        @(negedge clk);
        bus1.REG_WRITE = 1'b1; bus1.ADDRESS3 = 5'd5; bus1.WRITE_DATA3 = 32'd6;
        bus1.RADDR = {5'd9, 5'd5};
        #1;
        n_total++;
        if (bus1.RDATA[31:0] !== 32'd6) $display("FAIL bypass_x5: got %h want 6", bus1.RDATA[31:0]);
        else n_pass++;
        @(negedge clk);
        idle1();
        #1;
        n_total++;
        if (bus1.RDATA[31:0] !== 32'd6) $display("FAIL store_x5: got %h want 6", bus1.RDATA[31:0]);
        else n_pass++;
        @(negedge clk);
        bus1.REG_WRITE = 1'b1; bus1.ADDRESS3 = 5'd9; bus1.WRITE_DATA3 = 32'h2004;
        #1;
        n_total++;
        if (bus1.RDATA[63:32] !== 32'h2004) $display("FAIL bypass_x9: got %h want 2004", bus1.RDATA[63:32]);
        else n_pass++;
        @(negedge clk);
        idle1();
        #1;
        n_total++;
        if (bus1.RDATA !== {32'h2004, 32'd6}) $display("FAIL store_x9_x5: got %h want 00002004_00000006", bus1.RDATA);
        else n_pass++;
    endtask

    task automatic test_x0();
        @(negedge clk);
        bus1.REG_WRITE = 1'b1; bus1.ADDRESS3 = 5'd0; bus1.WRITE_DATA3 = 32'hFFFF_FFFF;
        bus1.RESERVE = 1'b1; bus1.RESERVE_ADDR = 5'd0;
        bus1.RADDR = {5'd0, 5'd0};
        #1;
        n_total++;
        if (bus1.RDATA !== 64'd0) $display("FAIL x0_bypass: got %h want 0", bus1.RDATA);
        else n_pass++;
        n_total++;
        if (bus1.RREADY !== 2'b11) $display("FAIL x0_rready_now: got %b want 11", bus1.RREADY);
        else n_pass++;
        @(negedge clk);
        idle1();
        #1;
        n_total++;
        if (bus1.RDATA !== 64'd0) $display("FAIL x0_store: got %h want 0", bus1.RDATA);
        else n_pass++;
        n_total++;
        if (bus1.RREADY !== 2'b11) $display("FAIL x0_rready_next: got %b want 11", bus1.RREADY);
        else n_pass++;
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        bus1.RESERVE = 1'b1; bus1.RESERVE_ADDR = 5'd7;
        bus1.RADDR = {5'd5, 5'd7};
        #1;
        n_total++;
        if (bus1.RREADY !== 2'b11) $display("FAIL resv_same_cycle: got %b want 11", bus1.RREADY);
        else n_pass++;
        @(negedge clk);
        idle1();
        #1;
        n_total++;
        if (bus1.RREADY !== 2'b10) $display("FAIL resv_t1: got %b want 10", bus1.RREADY);
        else n_pass++;
        @(negedge clk);
        #1;
        n_total++;
        if (bus1.RREADY !== 2'b10) $display("FAIL resv_t2: got %b want 10", bus1.RREADY);
        else n_pass++;
        @(negedge clk);
        bus1.REG_WRITE = 1'b1; bus1.ADDRESS3 = 5'd7; bus1.WRITE_DATA3 = 32'h55;
        #1;
        n_total++;
        if (bus1.RREADY !== 2'b11 || bus1.RDATA[31:0] !== 32'h55)
            $display("FAIL wb_t3: got rready=%b data=%h want 11/55", bus1.RREADY, bus1.RDATA[31:0]);
        else n_pass++;
        @(negedge clk);
        idle1();
        #1;
        n_total++;
        if (bus1.RREADY !== 2'b11 || bus1.RDATA[31:0] !== 32'h55)
            $display("FAIL wb_t4: got rready=%b data=%h want 11/55", bus1.RREADY, bus1.RDATA[31:0]);
        else n_pass++;
        @(negedge clk);
        bus1.RESERVE = 1'b1; bus1.RESERVE_ADDR = 5'd7;
        bus1.REG_WRITE = 1'b1; bus1.ADDRESS3 = 5'd7; bus1.WRITE_DATA3 = 32'h66;
        bus1.RADDR = {5'd7, 5'd7};
        #1;
        n_total++;
        if (bus1.RREADY !== 2'b11 || bus1.RDATA !== {32'h66, 32'h66})
            $display("FAIL resv_wr_same: got rready=%b data=%h want 11/66_66", bus1.RREADY, bus1.RDATA);
        else n_pass++;
        @(negedge clk);
        idle1();
        #1;
        n_total++;
        if (bus1.RREADY !== 2'b00 || bus1.RDATA !== {32'h66, 32'h66})
            $display("FAIL resv_wins: got rready=%b data=%h want 00/66_66", bus1.RREADY, bus1.RDATA);
        else n_pass++;
        @(negedge clk);
        bus1.REG_WRITE = 1'b1; bus1.ADDRESS3 = 5'd7; bus1.WRITE_DATA3 = 32'h77;
        @(negedge clk);
        idle1();
        #1;
        n_total++;
        if (bus1.RREADY !== 2'b11 || bus1.RDATA !== {32'h77, 32'h77})
            $display("FAIL resv_cleared: got rready=%b data=%h want 11/77_77", bus1.RREADY, bus1.RDATA);
        else n_pass++;
    endtask

    task automatic test_mid_clear();
        int n;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus1.REG_WRITE = 1'b1; bus1.ADDRESS3 = 5'd12; bus1.WRITE_DATA3 = 32'hABC;
        bus1.RESERVE = 1'b1; bus1.RESERVE_ADDR = 5'd12;
        bus1.RADDR = {5'd12, 5'd12};
        #1;
        n_total++;
        if (bus1.BUSY !== 1'b1 || bus1.RDATA !== 64'd0 || bus1.RREADY !== 2'b00)
            $display("FAIL busy_outputs: got busy=%b data=%h rready=%b want 1/0/00",
                     bus1.BUSY, bus1.RDATA, bus1.RREADY);
        else n_pass++;
        @(negedge clk);
        idle1();
        count_busy(1, n);
        n_total++;
        if (n + 1 !== 31) $display("FAIL mid_clear_cycles: got %0d want 31", n + 1);
        else n_pass++;
        bus1.RADDR = {5'd5, 5'd12};
        #1;
        n_total++;
        if (bus1.RDATA !== 64'd0 || bus1.RREADY !== 2'b11)
            $display("FAIL busy_write_dropped: got data=%h rready=%b want 0/11", bus1.RDATA, bus1.RREADY);
        else n_pass++;
    endtask

    task automatic test_param();
        int n;
        @(negedge clk);
        rst2 = 1'b0;
        count_busy(2, n);
        n_total++;
        if (n !== 15) $display("FAIL p_clear_cycles: got %0d want 15", n);
        else n_pass++;
        @(negedge clk);
        bus2.REG_WRITE = 1'b1; bus2.ADDRESS3 = 4'd3; bus2.WRITE_DATA3 = 64'h1_0000_0000;
        bus2.RADDR = {4'd3, 4'd3, 4'd3};
        #1;
        n_total++;
        if (bus2.RDATA !== {3{64'h1_0000_0000}} || bus2.RREADY !== 3'b111)
            $display("FAIL p_bypass: got data=%h rready=%b want 3x100000000/111", bus2.RDATA, bus2.RREADY);
        else n_pass++;
        @(negedge clk);
        bus2.REG_WRITE = 1'b0;
        #1;
        n_total++;
        if (bus2.RDATA !== {3{64'h1_0000_0000}} || bus2.RREADY !== 3'b111)
            $display("FAIL p_store: got data=%h rready=%b want 3x100000000/111", bus2.RDATA, bus2.RREADY);
        else n_pass++;
    endtask

    initial begin
        rst  = 1'b1;
        rst2 = 1'b1;
        idle1();
        bus1.RADDR = '0;
        bus2.REG_WRITE = 1'b0; bus2.ADDRESS3 = '0; bus2.WRITE_DATA3 = '0;
        bus2.RESERVE = 1'b0; bus2.RESERVE_ADDR = '0; bus2.RADDR = '0;
        test_reset();
        test_write_read();
        test_x0();
        test_scoreboard();
        test_mid_clear();
        test_param();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file for the RISC-V core; successor to the fixed 32×32, two-read-port register file. It adds a configurable read-port count, hard-wired x0, write-to-read bypass, a per-register pending-write scoreboard, and a sequential clear engine that zeroes every register after reset. It sits between decode (read and reserve) and writeback (write).

## Interface
Parameters:
- XLEN, 32, register width in bits
- NREGS, 32, register count; power of two, ≥ 2
- NREAD, 2, number of read ports, ≥ 1
- AW, $clog2(NREGS), address width (derived, not overridden)

Ports:
- CLK  in  1  single clock; all state updates on its rising edge
- RST  in  1  reset; synchronous, active-high
- REG_WRITE  in  1  write enable
- ADDRESS3  in  AW  write address
- WRITE_DATA3  in  XLEN  write data
- RADDR  in  NREAD*AW  packed read addresses; port i is bits [i*AW +: AW]
- RDATA  out  NREAD*XLEN  packed read data, combinational
- RREADY  out  NREAD  port i operand is valid this cycle
- RESERVE  in  1  mark a register as having an in-flight producer
- RESERVE_ADDR  in  AW  register to reserve
- BUSY  out  1  clear engine active; core must stall

## Operation
- FSM states:
  - CLEAR: BUSY=1. Each cycle with RST=0, write 0 to ram[idx], then idx++. After idx=NREGS-1 is written, go to IDLE next cycle.
  - IDLE: BUSY=0.
- RST=1 in any state, including mid-CLEAR: state←CLEAR, idx←1, all pending bits←0. This also covers a simulation start with no preload.
- Register 0: never stored. Reads return 0 and RREADY=1 when not BUSY. Writes and reserves to address 0 are ignored.
- Write (IDLE, REG_WRITE=1, ADDRESS3≠0): ram[ADDRESS3]←WRITE_DATA3 at the clock edge. REG_WRITE is ignored while BUSY.
- Bypass: if REG_WRITE=1, ADDRESS3≠0, ADDRESS3==RADDR_i and not BUSY, then RDATA_i=WRITE_DATA3 in the same cycle. Otherwise RDATA_i=ram[RADDR_i].
- Scoreboard: one pending bit per register (bit 0 is constant 0).
  - RESERVE sets pending[RESERVE_ADDR].
  - REG_WRITE clears pending[ADDRESS3].
  - Same address, same cycle: reserve wins, so the bit ends at 1 (a new producer).
  - Writing a non-pending register is legal; the bit stays 0.
  - RESERVE is ignored while BUSY.
- RREADY_i = !BUSY && (!pending[RADDR_i] || (REG_WRITE && ADDRESS3==RADDR_i)).
- While BUSY: RDATA all zero, RREADY all zero.

## Timing
- Reset values: BUSY=1, RDATA=0, RREADY=0, all pending bits=0.
- Clear duration: BUSY stays high for NREGS-1 cycles after the first cycle sampled with RST=0. BUSY=0 in cycle NREGS-1, counting from 0. For NREGS=32 that is 31 cycles.
- Read latency: 0 cycles (combinational from RADDR and the write inputs).
- Write visibility:
  - Bypassed in the write cycle.
  - Read from storage from the next cycle on.
- Reserve visibility: RREADY drops in the cycle after RESERVE is sampled. No same-cycle reserve-to-read forwarding.
- Multiple read ports may address the same register. Each port resolves independently and identically.
- No read-before-write hazard exists. Bypass removes the need for the negedge-write trick.

## Structure
- Shared package rv_pkg holds:
  - XLEN_DEFAULT and NREGS_DEFAULT
  - regfile state enum {RF_IDLE, RF_CLEAR}
  - REG_ZERO=0
- Sub-module regfile_scoreboard (pending bits plus RREADY logic), parametrised by NREGS, NREAD and AW.
- Storage, clear FSM and bypass live in the top module. Storage is a plain reg array with one write port, so it can infer as LUT RAM.

## Test plan
- Reset clear: RST=1 for 2 cycles, then 0 → BUSY=1 for exactly 31 cycles. Afterwards RADDR={5,9} returns {0,0} and RREADY=2'b11.
- Write then read: write x5=6 in cycle t → RDATA0=6 in cycle t (bypass) and in t+1 (storage). Write x9=32'h2004 → port 1 reads 32'h2004.
- x0: write x0=32'hFFFF_FFFF and RESERVE x0 → RDATA=0 and RREADY=1 on every port addressing x0.
- Scoreboard: RESERVE x7 at t → RREADY for x7 is 0 at t+1. Write x7=0x55 at t+3 → RREADY=1 with RDATA=0x55 at t+3 (bypass) and at t+4. RESERVE and write x7 in the same cycle → pending stays 1.
- Mid-clear reset: RST pulsed at clear cycle 10 → idx restarts at 1 and BUSY lasts 31 more cycles. Writes issued during BUSY are discarded, so the target register reads 0 afterwards.
- Parametrised build: XLEN=64, NREGS=16, NREAD=3 → BUSY for 15 cycles. Three ports read x3 simultaneously after writing 64'h1_0000_0000 and all return that value.
